// File: rtl/ddma_pkg.sv
`default_nettype none
// ============================================================================
// ddma_pkg : shared channel-status and engine-state encodings for the DMA ctrl
// Revision : 1.0
// ============================================================================
package ddma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DONE    = 2'd2,
    ST_ABORTED = 2'd3
  } ddma_status_e;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_ARB   = 2'd1,
    ENG_ISSUE = 2'd2,
    ENG_WAIT  = 2'd3
  } ddma_eng_e;

endpackage
`default_nettype wire

// File: rtl/ddma_rr_arbiter.sv
`default_nettype none
// ============================================================================
// ddma_rr_arbiter : round-robin arbiter, one-hot grant, pointer moves on accept
// Revision : 1.0
// ============================================================================
module ddma_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  int            w_best;
  int            w_win;

  // r_ptr is the first channel searched; the winner is the smallest distance from it.
  always_comb begin
    w_best = N;
    w_win  = 0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i] && (((i - int'(r_ptr) + N) % N) < w_best)) begin
        w_best = (i - int'(r_ptr) + N) % N;
        w_win  = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = (w_best < N) && (i == w_win);
    end
    w_next = PW'((w_win + 1) % N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept && (|o_gnt)) begin
      r_ptr <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddma_mc_ctrl.sv
`default_nettype none
// ============================================================================
// ddma_mc_ctrl : multi-channel DMA controller issuing grain-bounded bursts
// Revision : 1.0
// ============================================================================
module ddma_mc_ctrl
  import ddma_pkg::*;
#(
  parameter  int MEMORY_BUS_WIDTH   = 32,
  parameter  int FLIT_WIDTH         = 32,
  parameter  int INTERLEAVING_GRAIN = 64,
  parameter  int NUM_CHANNELS       = 4,
  localparam int AW                 = MEMORY_BUS_WIDTH - 2,
  localparam int LW                 = $clog2(INTERLEAVING_GRAIN) + 1,
  localparam int CW                 = $clog2(NUM_CHANNELS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CHANNELS*AW-1:0] addr_in,
  input  logic [NUM_CHANNELS*AW-1:0] nbytes_in,
  input  logic [NUM_CHANNELS-1:0]    cmd_in,
  input  logic [NUM_CHANNELS-1:0]    abort_in,
  input  logic [NUM_CHANNELS-1:0]    irq_clr_in,
  output logic [NUM_CHANNELS*2-1:0]  status_out,
  output logic [NUM_CHANNELS-1:0]    irq_out,
  output logic                       req_valid_out,
  input  logic                       req_ready_in,
  output logic [AW-1:0]              req_addr_out,
  output logic [LW-1:0]              req_len_out,
  output logic [CW-1:0]              req_chan_out,
  input  logic                       rsp_done_in
);

  localparam int GB = $clog2(INTERLEAVING_GRAIN);

  // FLIT_WIDTH only exists so NoC-side integrations can pass it through.
  if (FLIT_WIDTH > 0) begin : g_flit_compat
  end

  ddma_eng_e                  r_state;
  logic                       r_valid;
  logic [AW-1:0]              r_req_addr;
  logic [LW-1:0]              r_len;
  logic [CW-1:0]              r_chan;

  logic [NUM_CHANNELS-1:0]    w_req;
  logic [NUM_CHANNELS-1:0]    w_gnt;
  logic [NUM_CHANNELS-1:0]    w_start;
  logic [NUM_CHANNELS*AW-1:0] w_addr_all;
  logic [NUM_CHANNELS*AW-1:0] w_rem_all;
  logic                       w_accept;
  logic [CW-1:0]              w_gnt_idx;
  logic [AW-1:0]              w_gnt_addr;
  logic [AW-1:0]              w_gnt_rem;
  logic [LW-1:0]              w_space;
  logic [LW-1:0]              w_gnt_len;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_rem;
    ddma_status_e  r_status;
    logic          r_irq;
    logic          r_abort_pend;
    logic [AW-1:0] w_addr_i;
    logic [AW-1:0] w_nb_i;
    logic          w_busy;
    logic          w_cmd_ok;
    logic          w_outst;
    logic          w_rsp_here;
    logic          w_abort_eff;
    logic          w_last;
    logic          w_irq_set;

    assign w_addr_i    = addr_in[c*AW +: AW];
    assign w_nb_i      = nbytes_in[c*AW +: AW];
    assign w_busy      = (r_status == ST_BUSY);
    assign w_cmd_ok    = cmd_in[c] && !w_busy;
    // A burst counts as outstanding from ISSUE onward: valid cannot be withdrawn.
    assign w_outst     = ((r_state == ENG_ISSUE) || (r_state == ENG_WAIT)) && (r_chan == CW'(c));
    assign w_rsp_here  = (r_state == ENG_WAIT) && rsp_done_in && (r_chan == CW'(c));
    assign w_abort_eff = abort_in[c] || r_abort_pend;
    assign w_last      = (r_rem == AW'(r_len));
    assign w_irq_set   = (w_cmd_ok && (w_nb_i == '0))
                      || (w_busy && abort_in[c] && !w_outst)
                      || (w_busy && w_rsp_here && (w_abort_eff || w_last));

    assign w_req[c]   = w_busy && (r_rem != '0) && !abort_in[c] && !r_abort_pend;
    assign w_start[c] = w_cmd_ok && (w_nb_i != '0);
    assign w_addr_all[c*AW +: AW] = r_addr;
    assign w_rem_all[c*AW +: AW]  = r_rem;
    assign status_out[2*c +: 2]   = r_status;
    assign irq_out[c]             = r_irq;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_addr       <= '0;
        r_rem        <= '0;
        r_status     <= ST_IDLE;
        r_irq        <= 1'b0;
        r_abort_pend <= 1'b0;
      end else begin
        r_irq <= (r_irq & ~irq_clr_in[c]) | w_irq_set;
        if (w_cmd_ok) begin
          r_addr       <= w_addr_i;
          r_rem        <= w_nb_i;
          r_abort_pend <= 1'b0;
          r_status     <= (w_nb_i == '0) ? ST_DONE : ST_BUSY;
        end else if (w_busy) begin
          if (w_rsp_here) begin
            r_addr <= r_addr + AW'(r_len);
            r_rem  <= r_rem - AW'(r_len);
            if (w_abort_eff) begin
              r_status     <= ST_ABORTED;
              r_abort_pend <= 1'b0;
            end else if (w_last) begin
              r_status <= ST_DONE;
            end
          end else if (abort_in[c]) begin
            if (w_outst) begin
              r_abort_pend <= 1'b1;
            end else begin
              r_status <= ST_ABORTED;
            end
          end
        end
      end
    end
  end

  assign w_accept = (r_state == ENG_ARB);

  ddma_rr_arbiter #(
    .N (NUM_CHANNELS)
  ) u_arb (
    .clk      (clock),
    .rst      (reset),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    w_gnt_rem  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = CW'(i);
        w_gnt_addr = w_addr_all[i*AW +: AW];
        w_gnt_rem  = w_rem_all[i*AW +: AW];
      end
    end
  end

  // Bytes left before the next grain boundary caps the burst length.
  assign w_space   = LW'(INTERLEAVING_GRAIN) - {1'b0, w_gnt_addr[GB-1:0]};
  assign w_gnt_len = (w_gnt_rem < AW'(w_space)) ? w_gnt_rem[LW-1:0] : w_space;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ENG_IDLE;
      r_valid    <= 1'b0;
      r_req_addr <= '0;
      r_len      <= '0;
      r_chan     <= '0;
    end else begin
      case (r_state)
        ENG_IDLE: begin
          if ((|w_req) || (|w_start)) begin
            r_state <= ENG_ARB;
          end
        end
        ENG_ARB: begin
          if (|w_gnt) begin
            r_state    <= ENG_ISSUE;
            r_valid    <= 1'b1;
            r_chan     <= w_gnt_idx;
            r_req_addr <= w_gnt_addr;
            r_len      <= w_gnt_len;
          end else begin
            r_state <= ENG_IDLE;
          end
        end
        ENG_ISSUE: begin
          if (req_ready_in) begin
            r_valid <= 1'b0;
            r_state <= ENG_WAIT;
          end
        end
        ENG_WAIT: begin
          if (rsp_done_in) begin
            r_state <= ENG_ARB;
          end
        end
        default: r_state <= ENG_IDLE;
      endcase
    end
  end

  assign req_valid_out = r_valid;
  assign req_addr_out  = r_req_addr;
  assign req_len_out   = r_len;
  assign req_chan_out  = r_chan;

endmodule
`default_nettype wire

// File: tb/tb_ddma_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ddma_mc_ctrl : directed self-checking bench for the multi-channel DMA ctrl
// Revision : 1.0
// ============================================================================
module tb_ddma_mc_ctrl;

  localparam int AW = 30;
  localparam int LW = 7;
  localparam int NC = 4;
  localparam int CW = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NC*AW-1:0] addr_in = '0;
  logic [NC*AW-1:0] nbytes_in = '0;
  logic [NC-1:0]    cmd_in = '0;
  logic [NC-1:0]    abort_in = '0;
  logic [NC-1:0]    irq_clr_in = '0;
  logic [NC*2-1:0]  status_out;
  logic [NC-1:0]    irq_out;
  logic             req_valid_out;
  logic             req_ready_in = 1'b1;
  logic [AW-1:0]    req_addr_out;
  logic [LW-1:0]    req_len_out;
  logic [CW-1:0]    req_chan_out;
  logic             rsp_done_in = 1'b0;

  int checks = 0;
  int errors = 0;

  ddma_mc_ctrl #(
    .MEMORY_BUS_WIDTH   (32),
    .FLIT_WIDTH         (32),
    .INTERLEAVING_GRAIN (64),
    .NUM_CHANNELS       (NC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .addr_in       (addr_in),
    .nbytes_in     (nbytes_in),
    .cmd_in        (cmd_in),
    .abort_in      (abort_in),
    .irq_clr_in    (irq_clr_in),
    .status_out    (status_out),
    .irq_out       (irq_out),
    .req_valid_out (req_valid_out),
    .req_ready_in  (req_ready_in),
    .req_addr_out  (req_addr_out),
    .req_len_out   (req_len_out),
    .req_chan_out  (req_chan_out),
    .rsp_done_in   (rsp_done_in)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cmd_in = '0; abort_in = '0; irq_clr_in = '0; rsp_done_in = 1'b0;
    req_ready_in = 1'b1; addr_in = '0; nbytes_in = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_chan(input int c, input int a, input int nb);
    addr_in[c*AW +: AW]   = AW'(a);
    nbytes_in[c*AW +: AW] = AW'(nb);
  endtask

  function automatic logic [1:0] st(input int c);
    return status_out[2*c +: 2];
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Accepts the pending burst immediately and returns its completion one cycle later.
  task automatic serve_burst(output bit ok, output logic [AW-1:0] a,
                             output logic [LW-1:0] l, output logic [CW-1:0] c);
    wait_valid(ok);
    a = req_addr_out;
    l = req_len_out;
    c = req_chan_out;
    req_ready_in = 1'b1;
    tick();
    rsp_done_in = 1'b1;
    tick();
    rsp_done_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", status_out); end
    checks++; if (irq_out !== 4'h0) begin errors++; $display("FAIL reset_irq got %h want 0", irq_out); end
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", req_valid_out); end
    checks++; if (req_addr_out !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", req_addr_out); end
    checks++; if (req_len_out !== '0) begin errors++; $display("FAIL reset_len got %0d want 0", req_len_out); end
    checks++; if (req_chan_out !== '0) begin errors++; $display("FAIL reset_chan got %0d want 0", req_chan_out); end
  endtask

  task automatic test_two_bursts();
    bit ok; logic [AW-1:0] a; logic [LW-1:0] l; logic [CW-1:0] c;
    do_reset();
    set_chan(0, 'h10, 100);
    cmd_in[0] = 1'b1;
    tick();
    cmd_in[0] = 1'b0;
    checks++; if (st(0) !== 2'd1) begin errors++; $display("FAIL start_busy got %0d want 1", st(0)); end
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL latency_t1 valid got %b want 0", req_valid_out); end
    tick();
    checks++; if (req_valid_out !== 1'b1) begin errors++; $display("FAIL latency_t2 valid got %b want 1", req_valid_out); end
    serve_burst(ok, a, l, c);
    checks++;
    if (!ok || a !== 'h10 || l !== 7'd48 || c !== 2'd0) begin
      errors++; $display("FAIL burst1 ok=%0b addr=%h len=%0d chan=%0d want addr=10 len=48 chan=0", ok, a, l, c);
    end
    checks++; if (st(0) !== 2'd1 || irq_out[0] !== 1'b0) begin errors++; $display("FAIL mid_busy status=%0d irq=%b want 1 0", st(0), irq_out[0]); end
    serve_burst(ok, a, l, c);
    checks++;
    if (!ok || a !== 'h40 || l !== 7'd52 || c !== 2'd0) begin
      errors++; $display("FAIL burst2 ok=%0b addr=%h len=%0d chan=%0d want addr=40 len=52 chan=0", ok, a, l, c);
    end
    checks++; if (st(0) !== 2'd2 || irq_out[0] !== 1'b1) begin errors++; $display("FAIL done_irq status=%0d irq=%b want 2 1", st(0), irq_out[0]); end
    irq_clr_in[0] = 1'b1;
    tick();
    irq_clr_in[0] = 1'b0;
    checks++; if (irq_out[0] !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq_out[0]); end
  endtask

  task automatic test_round_robin();
    bit ok; logic [AW-1:0] a; logic [LW-1:0] l; logic [CW-1:0] c;
    logic [CW-1:0] exp_c [4];
    logic [AW-1:0] exp_a [4];
    exp_c[0] = 2'd0; exp_c[1] = 2'd2; exp_c[2] = 2'd0; exp_c[3] = 2'd2;
    exp_a[0] = 'h0;  exp_a[1] = 'h1000; exp_a[2] = 'h40; exp_a[3] = 'h1040;
    do_reset();
    set_chan(0, 'h0, 128);
    set_chan(2, 'h1000, 128);
    cmd_in = 4'b0101;
    tick();
    cmd_in = '0;
    for (int k = 0; k < 4; k++) begin
      serve_burst(ok, a, l, c);
      checks++;
      if (!ok || c !== exp_c[k] || a !== exp_a[k] || l !== 7'd64) begin
        errors++;
        $display("FAIL rr_grant%0d ok=%0b chan=%0d addr=%h len=%0d want chan=%0d addr=%h len=64",
                 k, ok, c, a, l, exp_c[k], exp_a[k]);
      end
    end
    checks++;
    if (st(0) !== 2'd2 || st(2) !== 2'd2 || irq_out !== 4'b0101) begin
      errors++; $display("FAIL rr_done st0=%0d st2=%0d irq=%b want 2 2 0101", st(0), st(2), irq_out);
    end
  endtask

  task automatic test_ready_stall();
    bit ok; int n;
    do_reset();
    req_ready_in = 1'b0;
    set_chan(3, 'h8, 20);
    cmd_in[3] = 1'b1;
    tick();
    cmd_in[3] = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_valid_timeout got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_valid_out !== 1'b1 || req_addr_out !== 'h8 || req_len_out !== 7'd20 || req_chan_out !== 2'd3) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b addr=%h len=%0d chan=%0d want 1 8 20 3",
                 i, req_valid_out, req_addr_out, req_len_out, req_chan_out);
      end
      if (i == 1) begin
        set_chan(3, 'h100, 4);
        cmd_in[3] = 1'b1;
      end
      tick();
      cmd_in[3] = 1'b0;
    end
    checks++; if (st(3) !== 2'd1) begin errors++; $display("FAIL busy_cmd_ignored status=%0d want 1", st(3)); end
    req_ready_in = 1'b1;
    tick();
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL single_handshake valid=%b want 0", req_valid_out); end
    rsp_done_in = 1'b1;
    tick();
    rsp_done_in = 1'b0;
    checks++; if (st(3) !== 2'd2 || irq_out[3] !== 1'b1) begin errors++; $display("FAIL stall_done status=%0d irq=%b want 2 1", st(3), irq_out[3]); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_valid_out === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL stall_extra_burst count=%0d want 0", n); end
  endtask

  task automatic test_abort_wait();
    bit ok; int n;
    do_reset();
    abort_in[0] = 1'b1;
    tick();
    abort_in[0] = 1'b0;
    checks++; if (st(0) !== 2'd0 || irq_out[0] !== 1'b0) begin errors++; $display("FAIL abort_idle_ignored status=%0d irq=%b want 0 0", st(0), irq_out[0]); end
    set_chan(1, 'h0, 256);
    cmd_in[1] = 1'b1;
    tick();
    cmd_in[1] = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || req_chan_out !== 2'd1) begin errors++; $display("FAIL abort_req ok=%0b chan=%0d want 1 1", ok, req_chan_out); end
    tick();
    set_chan(3, 'h200, 64);
    cmd_in[3] = 1'b1;
    tick();
    cmd_in[3] = 1'b0;
    abort_in[1] = 1'b1;
    abort_in[3] = 1'b1;
    tick();
    abort_in = '0;
    checks++; if (st(3) !== 2'd3 || irq_out[3] !== 1'b1) begin errors++; $display("FAIL abort_immediate status=%0d irq=%b want 3 1", st(3), irq_out[3]); end
    checks++; if (st(1) !== 2'd1 || irq_out[1] !== 1'b0) begin errors++; $display("FAIL abort_deferred status=%0d irq=%b want 1 0", st(1), irq_out[1]); end
    tick();
    tick();
    checks++; if (st(1) !== 2'd1) begin errors++; $display("FAIL abort_hold status=%0d want 1", st(1)); end
    rsp_done_in = 1'b1;
    tick();
    rsp_done_in = 1'b0;
    checks++; if (st(1) !== 2'd3 || irq_out[1] !== 1'b1) begin errors++; $display("FAIL abort_after_rsp status=%0d irq=%b want 3 1", st(1), irq_out[1]); end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid_out === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_more_bursts count=%0d want 0", n); end
  endtask

  task automatic test_zero_len();
    int n;
    do_reset();
    set_chan(2, 'h40, 0);
    cmd_in[2] = 1'b1;
    tick();
    cmd_in[2] = 1'b0;
    checks++; if (st(2) !== 2'd2 || irq_out[2] !== 1'b1) begin errors++; $display("FAIL zero_len_done status=%0d irq=%b want 2 1", st(2), irq_out[2]); end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_valid_out === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL zero_len_no_req count=%0d want 0", n); end
    irq_clr_in[2] = 1'b1;
    cmd_in[2] = 1'b1;
    tick();
    irq_clr_in[2] = 1'b0;
    cmd_in[2] = 1'b0;
    checks++; if (irq_out[2] !== 1'b1) begin errors++; $display("FAIL irq_set_priority got %b want 1", irq_out[2]); end
    irq_clr_in[2] = 1'b1;
    tick();
    irq_clr_in[2] = 1'b0;
    checks++; if (irq_out[2] !== 1'b0) begin errors++; $display("FAIL zero_len_irq_clear got %b want 0", irq_out[2]); end
  endtask

  task automatic test_reset_wait();
    bit ok;
    do_reset();
    set_chan(2, 'h0, 0);
    cmd_in[2] = 1'b1;
    tick();
    cmd_in[2] = 1'b0;
    set_chan(0, 'h80, 32);
    cmd_in[0] = 1'b1;
    tick();
    cmd_in[0] = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || irq_out[2] !== 1'b1) begin errors++; $display("FAIL rstw_setup ok=%0b irq2=%b want 1 1", ok, irq_out[2]); end
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL rstw_status got %h want 00", status_out); end
    checks++; if (irq_out !== 4'h0) begin errors++; $display("FAIL rstw_irq got %h want 0", irq_out); end
    checks++;
    if (req_valid_out !== 1'b0 || req_addr_out !== '0 || req_len_out !== '0 || req_chan_out !== '0) begin
      errors++; $display("FAIL rstw_req valid=%b addr=%h len=%0d chan=%0d want all 0",
                         req_valid_out, req_addr_out, req_len_out, req_chan_out);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    rsp_done_in = 1'b1;
    tick();
    rsp_done_in = 1'b0;
    tick();
    checks++;
    if (status_out !== 8'h00 || irq_out !== 4'h0 || req_valid_out !== 1'b0) begin
      errors++; $display("FAIL rstw_stale_rsp status=%h irq=%h valid=%b want 00 0 0", status_out, irq_out, req_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_round_robin();
    test_ready_stall();
    test_abort_wait();
    test_zero_len();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ddma_mc_ctrl.md
DDMA_MC_CTRL -- requirements
Module: ddma_mc_ctrl

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32, meaning memory bus width; AW = MEMORY_BUS_WIDTH-2.
REQ-002 SHALL have parameter FLIT_WIDTH, default 32, meaning NoC flit width (carried for compatibility; no internal use).
REQ-003 SHALL have parameter INTERLEAVING_GRAIN, default 64, meaning bytes per bank interleave (power of 2, >=4).
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, meaning independent DMA channels (>=2).
REQ-005 SHALL provide: clock  in  1  system clock; all logic on rising edge.
REQ-006 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL provide: addr_in  in  NUM_CHANNELS*AW  per-channel start byte address.
REQ-008 SHALL provide: nbytes_in  in  NUM_CHANNELS*AW  per-channel transfer length in bytes.
REQ-009 SHALL provide: cmd_in  in  NUM_CHANNELS  per-channel start pulse.
REQ-010 SHALL provide: abort_in  in  NUM_CHANNELS  per-channel abort pulse.
REQ-011 SHALL provide: irq_clr_in  in  NUM_CHANNELS  per-channel irq clear pulse.
REQ-012 SHALL provide: status_out  out  NUM_CHANNELS*2  per-channel state: 0 IDLE, 1 BUSY, 2 DONE, 3 ABORTED.
REQ-013 SHALL provide: irq_out  out  NUM_CHANNELS  per-channel sticky interrupt.
REQ-014 SHALL provide: req_valid_out  out  1; req_ready_in  in  1; req_addr_out  out  AW; req_len_out  out  clog2(GRAIN)+1; req_chan_out  out  clog2(NUM_CHANNELS) -- burst request to memory side.
REQ-015 SHALL provide: rsp_done_in  in  1  completion pulse for the single outstanding burst.

Function
REQ-016 SHALL latch addr/nbytes on cmd_in when channel status is not BUSY; status becomes BUSY the next cycle.
REQ-017 SHALL ignore cmd_in on a BUSY channel (no latch, no status change).
REQ-018 SHALL run one engine FSM: IDLE -> ARB (any channel BUSY with work) -> ISSUE -> WAIT -> ARB or IDLE.
REQ-019 SHALL arbitrate round-robin: the search starts at the channel after the last granted one, one burst per grant.
REQ-020 SHALL compute burst length = min(remaining, GRAIN - (addr mod GRAIN)); a burst never crosses a grain boundary.
REQ-021 SHALL hold req_valid_out and all req_* fields stable in ISSUE until req_ready_in is high; the transfer completes on valid&&ready.
REQ-022 SHALL allow at most one outstanding burst; WAIT exits on rsp_done_in, then the granted channel's addr += len and remaining -= len.
REQ-023 SHALL set DONE and irq when remaining reaches 0; nbytes=0 sets DONE and irq the cycle after cmd_in with no request issued.
REQ-024 SHALL handle abort_in on a BUSY channel with no outstanding burst by going ABORTED+irq next cycle; with an outstanding burst, it goes ABORTED+irq after rsp_done_in; abort on a non-BUSY channel is ignored.
REQ-025 SHALL give irq set priority over irq_clr_in when both occur in the same cycle.
REQ-026 SHALL minimum latency: cmd_in at cycle t -> req_valid_out high at t+2.
REQ-027 SHALL ignore rsp_done_in outside WAIT.

Reset
REQ-028 SHALL on reset force all status_out=IDLE, irq_out=0, req_valid_out=0, req_* =0, FSM=IDLE, RR pointer=0.
REQ-029 SHALL on reset mid-transfer drop the outstanding burst silently; no irq is raised.

Structure
REQ-030 SHALL place the status encoding enum and FSM state enum in shared package ddma_pkg.
REQ-031 SHALL implement arbitration in sub-module ddma_rr_arbiter (request vector in, one-hot grant out, pointer update on accept).

Verification
REQ-032 SHALL cover: ch0 addr=0x10, nbytes=100, GRAIN=64 -> bursts (0x10,48), (0x40,52); DONE+irq after second rsp_done.
REQ-033 SHALL cover: ch0 and ch2 started the same cycle with 128 bytes each, aligned -> grants alternate 0,2,0,2.
REQ-034 SHALL cover: req_ready_in low 5 cycles -> req_* held stable; single handshake.
REQ-035 SHALL cover: abort ch1 during WAIT -> status stays BUSY until rsp_done_in, then ABORTED, irq=1, no further bursts.
REQ-036 SHALL cover: nbytes=0 -> DONE+irq at t+1, req_valid_out never high; irq_clr_in and completion same cycle -> irq=1.
REQ-037 SHALL cover: reset asserted in WAIT -> all outputs at reset values asynchronously, irq_out=0.
